rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-way round-robin arbiter that shares a single downstream resource (bus, memory port, chip-select group) among eight requesters. A registered 3-bit winner index drives a 3-to-8 decoder to produce the one-hot grant vector. An optional hold limit forces rotation when a requester monopolises the grant. The block sits between the requester ports and the shared resource's select logic.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per winner while others wait. Range 0–255; 0 means unlimited.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  arbitration enable; low forces release and blocks new grants.
- `req`  in  8  request vector; bit i high means requester i wants the resource. Held high for the whole transfer.
- `grant`  out  8  one-hot grant. Equals decode(`grant_idx`) when `grant_valid`=1, else 0.
- `grant_idx`  out  3  registered index of the current or last winner.
- `grant_valid`  out  1  high while a grant is active.
- `hold_cnt`  out  8  number of cycles the current grant has been held, minus 1.

## Operation
- Reset (async, `rst_n`=0): `grant`=0, `grant_idx`=0, `grant_valid`=0, `hold_cnt`=0, priority pointer `ptr`=0, state IDLE.
- scan(v, p): first set bit of v, searching p, p+1, …, 7, 0, … (mod 8).
- State IDLE, at each edge:
  - If `en`=1 and |`req`=1: go to GRANT with `grant_idx`=scan(`req`, `ptr`), `grant_valid`=1, `hold_cnt`=0.
  - Otherwise stay in IDLE.
- State GRANT, at each edge the arbiter evaluates these conditions:
  - release: `req`[`grant_idx`]=0.
  - timeout: `MAX_HOLD`≠0 and `hold_cnt`=`MAX_HOLD`-1 and some other bit of `req` is set.
  - disable: `en`=0.
- In GRANT, if disable: go to IDLE, `grant_valid`=0, `ptr`=`grant_idx`+1 (mod 8).
- In GRANT, else if release or timeout:
  - `ptr`=`grant_idx`+1 (mod 8).
  - If `req` is non-zero: `grant_idx`=scan(`req`, `grant_idx`+1), `hold_cnt`=0, stay in GRANT.
  - On timeout the holder is scanned last, so a waiting competitor always wins.
  - If `req` is zero: go to IDLE, `grant_valid`=0.
- In GRANT, otherwise: `hold_cnt` increments.
  - If `hold_cnt` has reached `MAX_HOLD`-1 with no competitor, it holds there; rotation occurs at the first edge a competitor appears.
  - With `MAX_HOLD`=0, `hold_cnt` saturates at 255.
- `grant_idx` keeps its last value in IDLE.
- `ptr` is internal and changes only on a grant end.
- Simultaneous release and timeout are treated as a single rotation.
- A `req` bit rising on the same edge as a release is eligible for that edge's scan.

## Timing
- All outputs are registered; `grant` comes from a combinational decode of registers only.
- Request to grant: 1 cycle. `req` sampled at edge N gives `grant_valid`=1 after edge N.
- Handover: no idle cycle. The holder dropping `req` before edge N moves `grant` to the next winner after edge N.
- A grant never goes to a requester whose `req` was low at the deciding edge.
- Reset mid-grant: `grant` goes to 0 immediately (asynchronously), without waiting for a clock edge.

## Structure
- Package `arb_pkg`: `N_REQ`=8, `IDX_W`=3, `HOLD_W`=8, state enum {IDLE, GRANT}.
- Sub-module `dec3to8`: combinational 3-to-8 decoder with enable input.
  - Inputs: `grant_idx`, enable `grant_valid`.
  - Output: `grant`.
- Top level holds the FSM, pointer, hold counter and the rotating-priority scan.

## Test plan
- Reset, then `req`=8'h10 → after 1 edge `grant`=8'h10, `grant_idx`=4, `grant_valid`=1.
- `req`=8'hFF held, each holder drops its bit for one cycle on grant → `grant_idx` sequence 0,1,…,7,0 with no gap cycles.
- Holder 2 releases while `req`=8'h81 → next `grant_idx`=7; holder 7 then releases → `grant_idx`=0.
- `MAX_HOLD`=4, `req`=8'h03 held steady → requester 0 granted 4 cycles, requester 1 for 4 cycles, then requester 0 again. With `req`=8'h01 alone, the grant is held indefinitely and `hold_cnt` sticks at 3.
- `en` dropped mid-grant → `grant_valid`=0 at the next edge. `en` raised with `req` unchanged → grant goes to `ptr`, the old index + 1 if that requester is asserting.
- `rst_n` asserted mid-cycle during a grant → `grant`=0 immediately. After release, `req`=8'h20 yields `grant_idx`=5, scanned from `ptr`=0.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, state encoding and the rotating-priority scan helper.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  // First set bit of v, searching p, p+1, ... (mod N_REQ); returns p if v is zero.
  // Walking offsets from high to low lets the smallest offset overwrite last.
  function automatic logic [IDX_W-1:0] rr_scan(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    rr_scan = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = p + IDX_W'(k);
      if (v[idx]) rr_scan = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_8_dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is zero when disabled.
module dec3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] grant_idx,
  input  logic             grant_valid,
  output logic [N_REQ-1:0] grant
);

  // One-hot decode of the registered winner, gated by the valid flag.
  always_comb begin
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with optional hold limit forcing rotation.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic [HOLD_W-1:0] hold_cnt
);

  // Counter ceiling: MAX_HOLD-1 when limited, all-ones (saturation) when unlimited.
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    (MAX_HOLD == 0) ? '1 : HOLD_W'(MAX_HOLD - 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;

  logic [IDX_W-1:0] idx_inc;
  logic [N_REQ-1:0] holder_mask;
  logic             rel_c;
  logic             others_c;
  logic             timeout_c;

  // Grant-end conditions evaluated against the current holder.
  always_comb begin
    idx_inc     = grant_idx + IDX_W'(1);
    holder_mask = '0;
    holder_mask[grant_idx] = 1'b1;
    rel_c       = ~req[grant_idx];
    others_c    = |(req & ~holder_mask);
    timeout_c   = HOLD_EN && (hold_cnt == HOLD_LIM) && others_c;
  end

  // Arbitration FSM: winner index, valid, hold counter and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && |req) begin
            state       <= GRANT;
            grant_idx   <= rr_scan(req, ptr);
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (!en) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            ptr         <= idx_inc;
          end else if (rel_c || timeout_c) begin
            ptr <= idx_inc;
            if (|req) begin
              // Scanning from holder+1 places the holder last, so a
              // waiting competitor wins on timeout.
              grant_idx <= rr_scan(req, idx_inc);
              hold_cnt  <= '0;
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
            end
          end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  dec3to8 u_dec (
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (instance with MAX_HOLD=4).
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] hold_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .hold_cnt    (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx,
                             input logic vld, input logic [7:0] hc);
    logic [7:0] g;
    g = vld ? (8'h01 << idx) : 8'h00;
    check({tag, ".grant"}, {24'h0, grant}, {24'h0, g});
    check({tag, ".idx"},   {29'h0, grant_idx}, {29'h0, idx});
    check({tag, ".vld"},   {31'h0, grant_valid}, {31'h0, vld});
    check({tag, ".hold"},  {24'h0, hold_cnt}, {24'h0, hc});
  endtask

  initial begin
    logic [2:0] cur;
    logic [7:0] m;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    #3;
    check_grant("reset", 3'd0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First grant: single requester 4.
    en  = 1'b1;
    req = 8'h10;
    step();
    check_grant("first", 3'd4, 1'b1, 8'd0);

    // Release to idle (ptr becomes 5), then requester 7 wins from ptr 5.
    req = 8'h00;
    step();
    check_grant("rel_idle", 3'd4, 1'b0, 8'd0);
    req = 8'h80;
    step();
    check_grant("g7", 3'd7, 1'b1, 8'd0);

    // All requesting; holder drops its bit each cycle: 0,1,...,7,0 back-to-back.
    cur = 3'd7;
    for (int i = 0; i < 9; i++) begin
      m   = 8'h01 << cur;
      req = 8'hFF & ~m;
      step();
      cur = cur + 3'd1;
      check_grant("rotate", cur, 1'b1, 8'd0);
    end

    // Holder 0 -> 2, then 2 releases under 81 -> 7, then 7 releases -> 0.
    req = 8'h04;
    step();
    check_grant("to2", 3'd2, 1'b1, 8'd0);
    req = 8'h81;
    step();
    check_grant("to7", 3'd7, 1'b1, 8'd0);
    req = 8'h01;
    step();
    check_grant("to0", 3'd0, 1'b1, 8'd0);

    // Hold limit 4 with req=03 steady: 0 for 4 cycles, 1 for 4, then 0.
    req = 8'h03;
    step(); check_grant("to_a1", 3'd0, 1'b1, 8'd1);
    step(); check_grant("to_a2", 3'd0, 1'b1, 8'd2);
    step(); check_grant("to_a3", 3'd0, 1'b1, 8'd3);
    step(); check_grant("to_b0", 3'd1, 1'b1, 8'd0);
    step(); check_grant("to_b1", 3'd1, 1'b1, 8'd1);
    step(); check_grant("to_b2", 3'd1, 1'b1, 8'd2);
    step(); check_grant("to_b3", 3'd1, 1'b1, 8'd3);
    step(); check_grant("to_c0", 3'd0, 1'b1, 8'd0);

    // Lone requester: grant held, counter sticks at 3.
    req = 8'h01;
    step(); check_grant("sat1", 3'd0, 1'b1, 8'd1);
    step(); check_grant("sat2", 3'd0, 1'b1, 8'd2);
    step(); check_grant("sat3", 3'd0, 1'b1, 8'd3);
    step(); check_grant("sat4", 3'd0, 1'b1, 8'd3);
    step(); check_grant("sat5", 3'd0, 1'b1, 8'd3);

    // Disable mid-grant: valid drops, idx kept, ptr becomes 1.
    en = 1'b0;
    step();
    check("dis.grant", {24'h0, grant}, 32'h0);
    check("dis.vld", {31'h0, grant_valid}, 32'h0);
    check("dis.idx", {29'h0, grant_idx}, 32'h0);
    // Disabled in idle: no new grant.
    req = 8'hFF;
    step();
    check("dis_idle.vld", {31'h0, grant_valid}, 32'h0);
    // Re-enable: scan starts at ptr 1.
    req = 8'h03;
    en  = 1'b1;
    step();
    check_grant("reen", 3'd1, 1'b1, 8'd0);

    // Async reset mid-cycle during a grant.
    #3;
    rst_n = 1'b0;
    #1;
    check_grant("areset", 3'd0, 1'b0, 8'd0);
    #2;
    rst_n = 1'b1;
    req = 8'h20;
    step();
    check_grant("post_rst", 3'd5, 1'b1, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
